vec_mem_streamer: RTL and testbench
===================================

Name: vec_mem_streamer

Overview:
Parametrised successor to the single-port 8x4 Memory used for matrix/vector operand storage in the matrix-vector multiplier.
- One synchronous write port.
- One independent random-access read port (1-cycle latency).
- A burst streamer that emits a contiguous, address-wrapping run of words over a valid/ready handshake, so the MAC datapath can consume a matrix row or vector directly.

Parameters:
DATA_W, 8, word width in bits (signed data, stored and returned unmodified)
DEPTH, 16, number of words; must equal 2**ADDR_W
ADDR_W, 4, address width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe: mem[wr_addr] <= wr_data at clk edge
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data (signed)
rd_en  in  1  random read request
rd_addr  in  ADDR_W  random read address
rd_data  out  DATA_W  registered random read data
stream_start  in  1  start a burst (accepted only when busy=0)
stream_base  in  ADDR_W  first burst address
stream_len  in  ADDR_W+1  burst length in words, 1..DEPTH
out_valid  out  1  stream word valid
out_ready  in  1  consumer ready
out_data  out  DATA_W  stream word
out_last  out  1  high with the final word of the burst
busy  out  1  high while state=STREAM
err  out  1  one-cycle pulse on a rejected start

Behaviour:
- Reset (async assert, sync-to-clk deassert by the caller):
  - rd_data, out_data = 0; out_valid, out_last, busy, err = 0; FSM = IDLE.
  - Memory array is not reset; contents are undefined until written.
- Write: single cycle, no handshake. Writes are accepted in every state, including during reset deassertion edges.
- Random read:
  - rd_en at edge T loads rd_data with mem[rd_addr] at T+1.
  - rd_data holds when rd_en=0.
  - Read-first: a same-address write in the same cycle returns the old word.
- FSM IDLE -> STREAM: stream_start=1 with busy=0 and 1<=stream_len<=DEPTH. At that edge:
  - ptr <= stream_base+1; remaining <= stream_len-1.
  - out_data <= mem[stream_base]; out_valid <= 1; out_last <= (stream_len==1); busy <= 1.
  - First word is visible one cycle after start.
- STREAM, handshake (out_valid & out_ready at edge):
  - If remaining>0: out_data <= mem[ptr]; ptr <= ptr+1 (mod DEPTH); remaining <= remaining-1; out_last <= (remaining==1). No bubble between words.
  - If remaining==0 (last word accepted): out_valid, out_last, busy <= 0; FSM -> IDLE.
- STREAM, no handshake: out_data, out_valid and out_last hold stable. The valid/ready rule is that valid is never dropped before ready.
- Address wrap: ptr increments modulo DEPTH. base=DEPTH-2, len=4 reads addresses DEPTH-2, DEPTH-1, 0, 1.
- Coherence:
  - Each word is sampled from memory at the edge it is loaded into out_data (read-first).
  - A write to an address not yet loaded is seen by the stream.
  - A write to the word currently held in out_data does not change it.
- Rejected starts (err=1 for one cycle, state unchanged):
  - stream_start while busy=1, including the cycle of the final handshake.
  - stream_start with stream_len==0 or stream_len>DEPTH.
- Simultaneous events:
  - rd_en and streaming are fully independent; both may read any address in the same cycle.
  - wr_en plus reads to the same address: both read ports return the old data.
- Reset mid-burst: all outputs clear immediately (async); FSM = IDLE; the burst is abandoned and no out_last is produced.
- Widths: stream_len is ADDR_W+1 bits, so len=DEPTH is representable. remaining uses ADDR_W bits.

Test Plan:
1. Write mem[0..15] = 3*i-20 (signed, e.g. mem[0] = -20). Random read addr 5 -> rd_data = -5 on the next cycle. A concurrent write of 7 to addr 5 in the read cycle -> rd_data still -5; a reread gives 7.
2. With out_ready=1, start base=2 len=4 -> out_data = mem[2..5] on 4 consecutive cycles. out_last only on mem[5]. busy falls the cycle after the last handshake.
3. Start base=14 len=4 with out_ready toggling 1,0,0,1,1,0,1 -> sequence mem[14], mem[15], mem[0], mem[1]. out_data and out_valid are stable through ready=0 cycles; exactly 4 handshakes occur.
4. Start len=0 -> err pulse, busy=0. Start len=17 -> err pulse. Start during a busy burst -> err pulse and the ongoing burst is unaltered.
5. Start len=16 base=0, then write 99 to addr 10 while word 3 is presented -> the stream delivers 99 at position 10. A write to the currently presented address does not alter out_data.
6. Assert rst_n=0 mid-burst (after 2 words) -> out_valid, busy and out_data are 0 without waiting for a clock edge. After release, start base=0 len=1 -> a single word with out_last=1.

Source files
------------

// File: rtl/vec_mem_streamer_if.sv
// ============================================================================
// Module   : vec_mem_streamer_if
// Purpose  : Write / random-read / burst-stream bundle for vec_mem_streamer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vec_mem_streamer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              stream_start;
  logic [ADDR_W-1:0] stream_base;
  logic [ADDR_W:0]   stream_len;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              err;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output stream_start, stream_base, stream_len, out_ready,
    input  rd_data, out_valid, out_data, out_last, busy, err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  stream_start, stream_base, stream_len, out_ready,
    output rd_data, out_valid, out_data, out_last, busy, err
  );
endinterface

`default_nettype wire

// File: rtl/vec_mem_streamer.sv
// ============================================================================
// Module   : vec_mem_streamer
// Purpose  : Operand RAM with a write port, a 1-cycle random read port and a
//            wrapping valid/ready burst streamer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_mem_streamer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vec_mem_streamer_if.slave    bus
);

  localparam logic [ADDR_W:0]   LEN_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] REM_ONE = ADDR_W'(1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] rem_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              busy_q;
  logic              err_q;

  logic              len_ok_d;

  assign len_ok_d = (bus.stream_len != '0) && (bus.stream_len <= LEN_MAX);

  // Storage is deliberately unreset so writes land even while rst_n is low.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (bus.rd_en) begin
      rd_data_q <= mem_q[bus.rd_addr];
    end
  end

  // Words are fetched at the edge they enter out_data, so later writes to
  // not-yet-loaded addresses are observed by the burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.stream_start) begin
            if (len_ok_d) begin
              state_q     <= S_STREAM;
              ptr_q       <= bus.stream_base + 1'b1;
              rem_q       <= bus.stream_len[ADDR_W-1:0] - 1'b1;
              out_data_q  <= mem_q[bus.stream_base];
              out_valid_q <= 1'b1;
              out_last_q  <= (bus.stream_len == LEN_ONE);
              busy_q      <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (bus.stream_start) begin
            err_q <= 1'b1;
          end
          if (out_valid_q && bus.out_ready) begin
            if (rem_q != '0) begin
              out_data_q <= mem_q[ptr_q];
              ptr_q      <= ptr_q + 1'b1;
              rem_q      <= rem_q - 1'b1;
              out_last_q <= (rem_q == REM_ONE);
            end else begin
              state_q     <= S_IDLE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_vec_mem_streamer.sv
// ============================================================================
// Module   : tb_vec_mem_streamer
// Purpose  : Self-checking bench for vec_mem_streamer against a memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vec_mem_streamer;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   mem_m [16];

  vec_mem_streamer_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  vec_mem_streamer #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int exp;
  } rd_vec_t;

  typedef struct {
    int base;
    int len;
    int exp_err;
  } st_vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input int d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a[3:0];
    bus.wr_data = d[7:0];
    tick();
    bus.wr_en   = 1'b0;
    mem_m[a]    = d;
  endtask

  // mode 0: ready always high, 1: ready from pat bits, 2: random ready + random reads
  task automatic run_stream(input int base, input int len, input int mode, input logic [15:0] pat);
    int  exp_q[$];
    int  idx;
    int  cyc;
    int  ra;
    logic rdy;
    for (int k = 0; k < len; k++) exp_q.push_back(mem_m[(base + k) % 16]);
    bus.stream_base  = base[3:0];
    bus.stream_len   = len[4:0];
    bus.stream_start = 1'b1;
    tick();
    bus.stream_start = 1'b0;
    check("start_busy", int'(bus.busy), 1);
    check("start_err", int'(bus.err), 0);
    idx = 0;
    cyc = 0;
    while (idx < len && cyc < 200) begin
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = (cyc < 16) ? pat[cyc] : 1'b1;
      else                rdy = 1'($urandom_range(0, 1));
      bus.out_ready = rdy;
      check("str_valid", int'(bus.out_valid), 1);
      check("str_data", int'($signed(bus.out_data)), exp_q[idx]);
      check("str_last", int'(bus.out_last), (idx == len - 1) ? 1 : 0);
      ra = 0;
      if (mode == 2) begin
        ra          = $urandom_range(0, 15);
        bus.rd_en   = 1'b1;
        bus.rd_addr = ra[3:0];
      end
      tick();
      cyc++;
      if (rdy) idx++;
      if (mode == 2) begin
        check("par_rd", int'($signed(bus.rd_data)), mem_m[ra]);
        bus.rd_en = 1'b0;
      end
    end
    bus.out_ready = 1'b0;
    check("handshakes", idx, len);
    check("end_busy", int'(bus.busy), 0);
    check("end_valid", int'(bus.out_valid), 0);
  endtask

  initial begin
    rd_vec_t rd_tab [4];
    st_vec_t st_tab [5];
    int      e [16];
    int      idx;
    int      cyc;
    logic    done12;

    n_tests = 0;
    n_fail  = 0;
    rst_n            = 1'b0;
    bus.wr_en        = 1'b0;
    bus.wr_addr      = '0;
    bus.wr_data      = '0;
    bus.rd_en        = 1'b0;
    bus.rd_addr      = '0;
    bus.stream_start = 1'b0;
    bus.stream_base  = '0;
    bus.stream_len   = '0;
    bus.out_ready    = 1'b0;

    rd_tab[0] = '{addr: 5,  exp: -5};
    rd_tab[1] = '{addr: 0,  exp: -20};
    rd_tab[2] = '{addr: 15, exp: 25};
    rd_tab[3] = '{addr: 9,  exp: 7};

    st_tab[0] = '{base: 0,  len: 0,  exp_err: 1};
    st_tab[1] = '{base: 3,  len: 17, exp_err: 1};
    st_tab[2] = '{base: 1,  len: 31, exp_err: 1};
    st_tab[3] = '{base: 14, len: 16, exp_err: 0};
    st_tab[4] = '{base: 6,  len: 1,  exp_err: 0};

    #3;
    check("rst_rd_data", int'(bus.rd_data), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_last", int'(bus.out_last), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_err", int'(bus.err), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Test 1: fill, random reads, read-first
    for (int i = 0; i < 16; i++) write_word(i, 3 * i - 20);
    foreach (rd_tab[i]) begin
      bus.rd_en   = 1'b1;
      bus.rd_addr = rd_tab[i].addr[3:0];
      tick();
      bus.rd_en = 1'b0;
      check("rd_tab", int'($signed(bus.rd_data)), rd_tab[i].exp);
      tick();
      check("rd_hold", int'($signed(bus.rd_data)), rd_tab[i].exp);
    end
    bus.rd_en   = 1'b1;
    bus.rd_addr = 4'd5;
    write_word(5, 7);
    check("rd_first", int'($signed(bus.rd_data)), -5);
    tick();
    bus.rd_en = 1'b0;
    check("rd_new", int'($signed(bus.rd_data)), 7);

    // Test 2 and 3
    run_stream(2, 4, 0, 16'h0000);
    run_stream(14, 4, 1, 16'h0059);

    // Test 4: start acceptance table
    foreach (st_tab[i]) begin
      bus.stream_base  = st_tab[i].base[3:0];
      bus.stream_len   = st_tab[i].len[4:0];
      bus.stream_start = 1'b1;
      tick();
      bus.stream_start = 1'b0;
      check("st_err", int'(bus.err), st_tab[i].exp_err);
      check("st_busy", int'(bus.busy), 1 - st_tab[i].exp_err);
      if (st_tab[i].exp_err == 0)
        check("st_first", int'($signed(bus.out_data)), mem_m[st_tab[i].base]);
      bus.out_ready = 1'b1;
      tick();
      check("st_err_pulse", int'(bus.err), 0);
      cyc = 0;
      while (bus.busy && cyc < 40) begin
        tick();
        cyc++;
      end
      bus.out_ready = 1'b0;
      check("st_drain", int'(bus.busy), 0);
    end

    // Start while busy leaves the burst untouched
    bus.stream_base  = 4'd0;
    bus.stream_len   = 5'd3;
    bus.stream_start = 1'b1;
    tick();
    bus.stream_base  = 4'd9;
    bus.stream_len   = 5'd2;
    tick();
    bus.stream_start = 1'b0;
    check("busy_err", int'(bus.err), 1);
    check("busy_keep", int'(bus.busy), 1);
    tick();
    check("busy_err_pulse", int'(bus.err), 0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("busy_seq", int'($signed(bus.out_data)), mem_m[k]);
      check("busy_last", int'(bus.out_last), (k == 2) ? 1 : 0);
      tick();
    end
    bus.out_ready = 1'b0;
    check("busy_done", int'(bus.busy), 0);

    // Start on the final handshake is rejected
    bus.stream_base  = 4'd4;
    bus.stream_len   = 5'd2;
    bus.stream_start = 1'b1;
    tick();
    bus.stream_start = 1'b0;
    bus.out_ready    = 1'b1;
    tick();
    bus.stream_start = 1'b1;
    tick();
    bus.stream_start = 1'b0;
    bus.out_ready    = 1'b0;
    check("fin_err", int'(bus.err), 1);
    check("fin_busy", int'(bus.busy), 0);
    check("fin_valid", int'(bus.out_valid), 0);
    tick();
    check("fin_idle", int'(bus.busy), 0);

    // Test 5: coherence with writes during a full burst
    for (int i = 0; i < 16; i++) e[i] = mem_m[i];
    bus.stream_base  = 4'd0;
    bus.stream_len   = 5'd16;
    bus.stream_start = 1'b1;
    tick();
    bus.stream_start = 1'b0;
    idx    = 0;
    cyc    = 0;
    done12 = 1'b0;
    while (idx < 16 && cyc < 40) begin
      bus.out_ready = 1'b1;
      check("coh_data", int'($signed(bus.out_data)), e[idx]);
      if (idx == 3) begin
        bus.wr_en = 1'b1; bus.wr_addr = 4'd10; bus.wr_data = 8'd99;
        mem_m[10] = 99;
        e[10]     = 99;
      end else if (idx == 12 && !done12) begin
        bus.out_ready = 1'b0;
        bus.wr_en = 1'b1; bus.wr_addr = 4'd12; bus.wr_data = 8'd55;
        mem_m[12] = 55;
        done12    = 1'b1;
      end
      tick();
      bus.wr_en = 1'b0;
      cyc++;
      if (bus.out_ready) idx++;
    end
    bus.out_ready = 1'b0;
    check("coh_count", idx, 16);
    check("coh_busy", int'(bus.busy), 0);

    // Test 6: async reset mid-burst
    bus.stream_base  = 4'd0;
    bus.stream_len   = 5'd8;
    bus.stream_start = 1'b1;
    tick();
    bus.stream_start = 1'b0;
    bus.out_ready    = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", int'(bus.out_valid), 0);
    check("arst_busy", int'(bus.busy), 0);
    check("arst_data", int'(bus.out_data), 0);
    check("arst_last", int'(bus.out_last), 0);
    bus.out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run_stream(0, 1, 0, 16'h0000);

    // Randomized bursts with concurrent random reads
    for (int it = 0; it < 20; it++) begin
      for (int w = 0; w < 3; w++)
        write_word($urandom_range(0, 15), $urandom_range(0, 255) - 128);
      run_stream($urandom_range(0, 15), $urandom_range(1, 16), 2, 16'h0000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
